// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor main control FSM: Moore strobe decode plus retired-instruction counter.
// Define MULTI_CYCLE_CTRL_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        mem_ready,
    output logic        IRWrite,
    output logic        NextPC,
    output logic        RegW,
    output logic        MemW,
    output logic        Branch,
    output logic        AdrSrc,
    output logic        ALUOp,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        retire;
    logic        mem_go;
    logic        unused_bits;

`ifdef MULTI_CYCLE_CTRL_WAIT_EN
    assign mem_go      = mem_ready;
    assign unused_bits = ^Funct[4:1];
`else
    // Without wait states the memory is assumed single-cycle.
    assign mem_go      = 1'b1;
    assign unused_bits = ^{Funct[4:1], mem_ready};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        // Undefined op retires as a NOP.
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_go) state_d = S_MEMWB;
            S_MEMWRITE: begin
                if (mem_go) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            // Illegal codes recover silently without counting.
            default:    state_d = S_FETCH;
        endcase
        instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUOp     = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_go;
                NextPC    = mem_go;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECUTER: ALUOp = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB:    RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus queues per-cycle expectations, a negedge monitor checks them.
// Build with MULTI_CYCLE_CTRL_WAIT_EN defined to also exercise memory wait states.
module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [5:0]  Funct = 6'b000000;
    logic        mem_ready = 1'b1;
    logic        IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  state;
    logic [15:0] instr_count;

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .AdrSrc(AdrSrc), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_count = 16'd0;
    logic [12:0] act_outs;

    // {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUOp,ResultSrc,ALUSrcA,ALUSrcB}
    assign act_outs = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, ResultSrc, ALUSrcA, ALUSrcB};

    function automatic logic [12:0] ref_outs(input logic [3:0] st, input logic mr);
        logic g;
`ifdef MULTI_CYCLE_CTRL_WAIT_EN
        g = mr;
`else
        g = 1'b1 | mr;
`endif
        case (st)
            4'd0:    ref_outs = {g, g, 5'b00000, 2'b10, 2'b01, 2'b10};
            4'd1:    ref_outs = {7'b0000000, 2'b10, 2'b01, 2'b10};
            4'd2:    ref_outs = {7'b0000000, 2'b00, 2'b00, 2'b01};
            4'd3:    ref_outs = {7'b0000010, 2'b00, 2'b00, 2'b00};
            4'd4:    ref_outs = {7'b0010000, 2'b01, 2'b00, 2'b00};
            4'd5:    ref_outs = {7'b0001010, 2'b00, 2'b00, 2'b00};
            4'd6:    ref_outs = {7'b0000001, 2'b00, 2'b00, 2'b00};
            4'd7:    ref_outs = {7'b0000001, 2'b00, 2'b00, 2'b01};
            4'd8:    ref_outs = {7'b0010000, 2'b00, 2'b00, 2'b00};
            4'd9:    ref_outs = {7'b0000100, 2'b10, 2'b00, 2'b01};
            default: ref_outs = 13'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            $display("cycle t=%0t state=%0d outs=%h count=%h (expect %0d %h %h)",
                     $time, state, act_outs, instr_count, mon_e.st, mon_e.outs, mon_e.cnt);
            checks++;
            if (state !== mon_e.st) begin
                errors++;
                $display("FAIL state: got %0d expected %0d at %0t", state, mon_e.st, $time);
            end
            checks++;
            if (act_outs !== mon_e.outs) begin
                errors++;
                $display("FAIL outputs: got %h expected %h at %0t", act_outs, mon_e.outs, $time);
            end
            checks++;
            if (instr_count !== mon_e.cnt) begin
                errors++;
                $display("FAIL instr_count: got %h expected %h at %0t", instr_count, mon_e.cnt, $time);
            end
        end
    end

    task automatic cyc(input logic [3:0] st);
        sb.push_back({st, ref_outs(st, mem_ready), exp_count});
        @(posedge clk);
        #1;
    endtask

    // seq holds the visited states as nibbles, first state in the most significant used nibble.
    task automatic instr(input logic [1:0] op, input logic [5:0] f, input int n, input logic [23:0] seq);
        Op    = op;
        Funct = f;
        for (int i = 0; i < n; i++) cyc(seq[4*(n-1-i) +: 4]);
        exp_count = exp_count + 16'd1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(4'd0);
        cyc(4'd0);
        reset = 1'b1;

        instr(2'b00, 6'h00, 4, 24'h000168);
        instr(2'b00, 6'h20, 4, 24'h000178);
        instr(2'b01, 6'h01, 5, 24'h001234);
        instr(2'b01, 6'h00, 4, 24'h000125);
        instr(2'b10, 6'h00, 3, 24'h000019);
        instr(2'b11, 6'h00, 2, 24'h000001);
        instr(2'b00, 6'h1E, 4, 24'h000168);
        instr(2'b01, 6'h3F, 5, 24'h001234);

`ifdef MULTI_CYCLE_CTRL_WAIT_EN
        Op = 2'b01; Funct = 6'h01;
        mem_ready = 1'b0;
        cyc(4'd0); cyc(4'd0);
        mem_ready = 1'b1;
        cyc(4'd0); cyc(4'd1); cyc(4'd2);
        mem_ready = 1'b0;
        cyc(4'd3); cyc(4'd3); cyc(4'd3);
        mem_ready = 1'b1;
        cyc(4'd3); cyc(4'd4);
        exp_count = exp_count + 16'd1;

        Funct = 6'h00;
        cyc(4'd0); cyc(4'd1); cyc(4'd2);
        mem_ready = 1'b0;
        cyc(4'd5); cyc(4'd5);
        mem_ready = 1'b1;
        cyc(4'd5);
        exp_count = exp_count + 16'd1;

        Funct = 6'h01;
        cyc(4'd0); cyc(4'd1); cyc(4'd2);
        mem_ready = 1'b0;
        cyc(4'd3);
        reset = 1'b0;
        exp_count = 16'd0;
        cyc(4'd0);
        mem_ready = 1'b1;
        reset = 1'b1;
        instr(2'b01, 6'h01, 5, 24'h001234);
`else
        mem_ready = 1'b0;
        instr(2'b01, 6'h01, 5, 24'h001234);
        instr(2'b01, 6'h00, 4, 24'h000125);
        instr(2'b00, 6'h00, 4, 24'h000168);
        mem_ready = 1'b1;
`endif

        // Abort mid-instruction: reset lands between edges while in EXECUTER.
        Op = 2'b00; Funct = 6'h00;
        cyc(4'd0); cyc(4'd1);
        reset = 1'b0;
        exp_count = 16'd0;
        cyc(4'd0);
        cyc(4'd0);
        reset = 1'b1;
        instr(2'b00, 6'h00, 4, 24'h000168);

        // Counter wrap: preset the counter to 0xFFFE, then retire two NOPs.
        Op = 2'b11; Funct = 6'h00;
        force dut.instr_count_q = 16'hFFFE;
        exp_count = 16'hFFFE;
        cyc(4'd0);
        release dut.instr_count_q;
        cyc(4'd1);
        exp_count = exp_count + 16'd1;
        instr(2'b11, 6'h00, 2, 24'h000001);
        cyc(4'd0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
